// File: rtl/cordic_stream_pkg.sv
// Shared definitions for the CORDIC input-stream arbiter.
//   arb_state_e : arbiter FSM encoding (idle / frame transfer)
//   DefaultDw   : default stream data width
//   SrcId0/1    : source ids carried on m_tid
package cordic_stream_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StXfer = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultDw = 16;

    localparam logic SrcId0 = 1'b0;
    localparam logic SrcId1 = 1'b1;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-stream output register (data + tid + tlast).
// Ports:
//   clk, resetn           clock, async active-low reset
//   load                  capture in_* into the register this edge
//   in_tdata/tid/tlast    beat to capture
//   in_ready              register can take a beat this cycle
//   m_tvalid/tdata/tid/tlast, m_tready   downstream AXI stream
module axis_out_reg #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [DW-1:0] in_tdata,
    input  logic          in_tid,
    input  logic          in_tlast,
    output logic          in_ready,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tid,
    output logic          m_tlast
);

    // Empty, or being drained this cycle: a new load replaces the entry without a bubble.
    assign in_ready = ~m_tvalid | m_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tid    <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= in_tdata;
            m_tid    <= in_tid;
            m_tlast  <= in_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/cordic_stream_arb.sv
// Frame-granular round-robin arbiter sharing the CORDIC input stream between two sources.
// A source is granted for exactly FRAME_LEN beats; each beat carries its source id on m_tid
// and the final beat carries m_tlast. At least one idle cycle separates frames.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   enable                           arbitrate new frames (never truncates a running frame)
//   s0_*, s1_*                       source AXI streams (tvalid/tready/tdata)
//   m_tvalid/tready/tdata/tid/tlast  stream to the CORDIC core
//   busy                             frame in progress or output beat pending
// Optional build macro CORDIC_ARB_STATS_EN adds frames0/frames1: completed-frame counters.
module cordic_stream_arb
    import cordic_stream_pkg::*;
#(
    parameter int unsigned DW        = DefaultDw,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned CNT_W     = 11
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          s0_tvalid,
    output logic          s0_tready,
    input  logic [DW-1:0] s0_tdata,
    input  logic          s1_tvalid,
    output logic          s1_tready,
    input  logic [DW-1:0] s1_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tid,
    output logic          m_tlast,
`ifdef CORDIC_ARB_STATS_EN
    output logic [15:0]   frames0,
    output logic [15:0]   frames1,
`endif
    output logic          busy
);

    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(FRAME_LEN - 1);

    arb_state_e       state;
    logic             grant;
    logic             last_grant;
    logic [CNT_W-1:0] beat_cnt;

    logic             out_ready;
    logic             sel_valid;
    logic [DW-1:0]    sel_data;
    logic             accept;
    logic             is_last;

    assign sel_valid = (grant == SrcId1) ? s1_tvalid : s0_tvalid;
    assign sel_data  = (grant == SrcId1) ? s1_tdata : s0_tdata;
    assign s0_tready = (state == StXfer) && (grant == SrcId0) && out_ready;
    assign s1_tready = (state == StXfer) && (grant == SrcId1) && out_ready;
    assign accept    = (state == StXfer) && sel_valid && out_ready;
    assign is_last   = (beat_cnt == LastBeat);
    assign busy      = (state != StIdle) || m_tvalid;

    // Grant decisions only look at registered state plus the valids sampled at the edge,
    // so there is no combinational path from s*_tvalid to the grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            grant      <= SrcId0;
            last_grant <= SrcId1;
            beat_cnt   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (enable && (s0_tvalid || s1_tvalid)) begin
                        if (s0_tvalid && s1_tvalid) begin
                            grant <= ~last_grant;
                        end else begin
                            grant <= s1_tvalid ? SrcId1 : SrcId0;
                        end
                        beat_cnt <= '0;
                        state    <= StXfer;
                    end
                end
                StXfer: begin
                    if (accept) begin
                        if (is_last) begin
                            last_grant <= grant;
                            beat_cnt   <= '0;
                            state      <= StIdle;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CORDIC_ARB_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frames0 <= '0;
            frames1 <= '0;
        end else if (accept && is_last) begin
            if (grant == SrcId1) begin
                frames1 <= frames1 + 16'd1;
            end else begin
                frames0 <= frames0 + 16'd1;
            end
        end
    end
`endif

    axis_out_reg #(
        .DW(DW)
    ) u_out (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept),
        .in_tdata (sel_data),
        .in_tid   (grant),
        .in_tlast (is_last),
        .in_ready (out_ready),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tid    (m_tid),
        .m_tlast  (m_tlast)
    );

endmodule

// File: tb/tb_cordic_stream_arb.sv
// Directed bench for cordic_stream_arb: a FRAME_LEN=64 instance for the main scenarios and
// a FRAME_LEN=1 instance for per-beat arbitration. Frame counters checked under
// CORDIC_ARB_STATS_EN.
module tb_cordic_stream_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        enable;
    logic        s0_tvalid, s1_tvalid, s0_tready, s1_tready;
    logic [15:0] s0_tdata, s1_tdata, m_tdata;
    logic        m_tvalid, m_tready, m_tid, m_tlast, busy;

    logic        enable1;
    logic        t1_s0_tready, t1_s1_tready;
    logic [15:0] t1_m_tdata;
    logic        t1_m_tvalid, t1_m_tid, t1_m_tlast, t1_busy;
`ifdef CORDIC_ARB_STATS_EN
    logic [15:0] frames0, frames1, t1_frames0, t1_frames1;
`endif

    cordic_stream_arb #(.DW(16), .FRAME_LEN(64), .CNT_W(11)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tid(m_tid), .m_tlast(m_tlast),
`ifdef CORDIC_ARB_STATS_EN
        .frames0(frames0), .frames1(frames1),
`endif
        .busy(busy)
    );

    cordic_stream_arb #(.DW(16), .FRAME_LEN(1), .CNT_W(11)) dut1 (
        .clk(clk), .resetn(resetn), .enable(enable1),
        .s0_tvalid(1'b1), .s0_tready(t1_s0_tready), .s0_tdata(16'h00AA),
        .s1_tvalid(1'b1), .s1_tready(t1_s1_tready), .s1_tdata(16'h00BB),
        .m_tvalid(t1_m_tvalid), .m_tready(1'b1), .m_tdata(t1_m_tdata),
        .m_tid(t1_m_tid), .m_tlast(t1_m_tlast),
`ifdef CORDIC_ARB_STATS_EN
        .frames0(t1_frames0), .frames1(t1_frames1),
`endif
        .busy(t1_busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    // Source / sink model state
    logic        en_s0, en_s1;
    int          rdy_mode;      // 0: m_tready=1, 1: toggle 1010...
    int          cyc;
    logic [15:0] s0_cnt, s1_cnt;
    logic [15:0] q_data[$];
    logic        q_tid[$];
    logic        q_last[$];
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_tid, prev_last;
    int          stall_err;

    task automatic clear_q();
        q_data.delete(); q_tid.delete(); q_last.delete();
        stall_err = 0;
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, commit at posedge.
    task automatic step();
        logic hs0, hs1;
        @(negedge clk);
        s0_tvalid = en_s0;
        s0_tdata  = s0_cnt;
        s1_tvalid = en_s1;
        s1_tdata  = 16'h8000 | s1_cnt;
        m_tready  = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
        #1;
        if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tid !== prev_tid ||
                           m_tlast !== prev_last)) begin
            stall_err++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_tid   = m_tid;
        prev_last  = m_tlast;
        if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_tid.push_back(m_tid);
            q_last.push_back(m_tlast);
        end
        hs0 = s0_tvalid && s0_tready;
        hs1 = s1_tvalid && s1_tready;
        @(posedge clk);
        if (hs0) s0_cnt++;
        if (hs1) s1_cnt++;
        cyc++;
    endtask

    task automatic collect(input int n, input int budget, output bit ok);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic drain(output bit ok);
        int k = 0;
        enable   = 1'b0;
        rdy_mode = 0;
        step();
        while (busy && k < 300) begin
            step();
            k++;
        end
        ok = !busy;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        enable = 1'b0; en_s0 = 1'b0; en_s1 = 1'b0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        prev_stall = 1'b0;
        s0_cnt = '0; s1_cnt = '0;
        @(negedge clk);
        resetn = 1'b1;
        clear_q();
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; enable1 = 1'b0;
        en_s0 = 1'b0; en_s1 = 1'b0; rdy_mode = 0; cyc = 0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tdata = '0; s1_tdata = '0; m_tready = 1'b1;
        s0_cnt = '0; s1_cnt = '0; prev_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid); end
        n_checks++; if (m_tdata !== 16'h0) begin n_fail++; $display("FAIL reset_tdata got %h exp 0", m_tdata); end
        n_checks++; if (m_tid !== 1'b0) begin n_fail++; $display("FAIL reset_tid got %b exp 0", m_tid); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b exp 0", m_tlast); end
        n_checks++; if (s0_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s0_tready got %b exp 0", s0_tready); end
        n_checks++; if (s1_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s1_tready got %b exp 0", s1_tready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(negedge clk);
        resetn = 1'b1;
        clear_q();
    endtask

    task automatic test_single_source();
        bit ok;
        enable = 1'b1; en_s0 = 1'b1; en_s1 = 1'b0; rdy_mode = 0;
        collect(64, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout got %0d beats exp 64", q_data.size()); end
        for (int i = 0; i < 64 && i < q_data.size(); i++) begin
            n_checks++;
            if (q_data[i] !== 16'(i) || q_tid[i] !== 1'b0 || q_last[i] !== (i == 63)) begin
                n_fail++;
                $display("FAIL single_beat[%0d] got d=%h id=%b l=%b exp d=%h id=0 l=%b",
                         i, q_data[i], q_tid[i], q_last[i], 16'(i), (i == 63));
            end
        end
        step();
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle_gap got tvalid=%b exp 0", m_tvalid); end
        step();
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'd64 || m_tid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_next_frame got v=%b d=%h id=%b exp v=1 d=0040 id=0", m_tvalid, m_tdata, m_tid);
        end
        drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_drain got busy=%b exp 0", busy); end
    endtask

    task automatic test_alternate();
        bit ok;
        logic [15:0] exp_d;
        apply_reset();
        enable = 1'b1; en_s0 = 1'b1; en_s1 = 1'b1; rdy_mode = 0;
        collect(192, 500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL alt_timeout got %0d beats exp 192", q_data.size()); end
        for (int i = 0; i < 192 && i < q_data.size(); i++) begin
            case (i / 64)
                0:       exp_d = 16'(i % 64);
                1:       exp_d = 16'h8000 | 16'(i % 64);
                default: exp_d = 16'(64 + i % 64);
            endcase
            n_checks++;
            if (q_data[i] !== exp_d || q_tid[i] !== 1'((i / 64) % 2) || q_last[i] !== ((i % 64) == 63)) begin
                n_fail++;
                $display("FAIL alt_beat[%0d] got d=%h id=%b l=%b exp d=%h id=%0d l=%b",
                         i, q_data[i], q_tid[i], q_last[i], exp_d, (i / 64) % 2, ((i % 64) == 63));
            end
        end
        drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL alt_drain got busy=%b exp 0", busy); end
    endtask

    task automatic test_stall();
        bit ok;
        int bad = 0;
        apply_reset();
        enable = 1'b1; en_s0 = 1'b1; en_s1 = 1'b0; rdy_mode = 1;
        collect(64, 400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got %0d beats exp 64", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 64; i++) begin
            if (q_data[i] !== 16'(i) || q_last[i] !== (i == 63)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_order got %0d bad beats exp 0", bad); end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes exp 0", stall_err); end
        drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_drain got busy=%b exp 0", busy); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int k = 0;
        apply_reset();
        enable = 1'b1; en_s0 = 1'b1; en_s1 = 1'b1; rdy_mode = 0;
        collect(10, 100, ok);
        enable = 1'b0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_timeout got busy=%b exp 0", busy); end
        n_checks++; if (q_data.size() != 64) begin n_fail++; $display("FAIL endrop_count got %0d exp 64", q_data.size()); end
        if (q_data.size() == 64) begin
            n_checks++;
            if (q_data[63] !== 16'd63 || q_last[63] !== 1'b1 || q_tid[63] !== 1'b0) begin
                n_fail++;
                $display("FAIL endrop_lastbeat got d=%h l=%b id=%b exp d=003f l=1 id=0", q_data[63], q_last[63], q_tid[63]);
            end
        end
        repeat (5) step();
        n_checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || s0_tready !== 1'b0 || s1_tready !== 1'b0 || q_data.size() != 64) begin
            n_fail++;
            $display("FAIL endrop_hold got busy=%b v=%b r0=%b r1=%b n=%0d exp 0 0 0 0 64",
                     busy, m_tvalid, s0_tready, s1_tready, q_data.size());
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [15:0] start;
        int bad = 0;
        apply_reset();
        enable = 1'b1; en_s0 = 1'b1; en_s1 = 1'b0; rdy_mode = 0;
        collect(20, 100, ok);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s0_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async got v=%b busy=%b r0=%b exp 0 0 0", m_tvalid, busy, s0_tready);
        end
        prev_stall = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        clear_q();
        start = s0_cnt;
        collect(64, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_timeout got %0d beats exp 64", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 64; i++) begin
            if (q_data[i] !== start + 16'(i) || q_tid[i] !== 1'b0 || q_last[i] !== (i == 63)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midreset_frame got %0d bad beats exp 0", bad); end
        drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_drain got busy=%b exp 0", busy); end
    endtask

    task automatic test_frame_len1();
        int got = 0;
        int k = 0;
        enable1 = 1'b1;
        while (got < 6 && k < 60) begin
            @(negedge clk);
            #1;
            if (t1_m_tvalid) begin
                n_checks++;
                if (t1_m_tid !== 1'(got % 2) || t1_m_tlast !== 1'b1 ||
                    t1_m_tdata !== ((got % 2) ? 16'h00BB : 16'h00AA)) begin
                    n_fail++;
                    $display("FAIL len1_beat[%0d] got id=%b l=%b d=%h exp id=%0d l=1 d=%h", got,
                             t1_m_tid, t1_m_tlast, t1_m_tdata, got % 2, (got % 2) ? 16'h00BB : 16'h00AA);
                end
                got++;
            end
            k++;
        end
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL len1_timeout got %0d beats exp 6", got); end
`ifdef CORDIC_ARB_STATS_EN
        n_checks++;
        if (t1_frames0 !== 16'd3 || t1_frames1 !== 16'd3) begin
            n_fail++;
            $display("FAIL len1_stats got f0=%0d f1=%0d exp 3 3", t1_frames0, t1_frames1);
        end
`endif
        enable1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_alternate();
        test_stall();
        test_enable_drop();
        test_reset_midframe();
        test_frame_len1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
